// File: rtl/pc_seq_ctrl_pkg.sv
// rtl/pc_seq_ctrl_pkg.sv - shared state encodings and default addresses for the PC sequencer
package pc_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_INT_PEND = 2'd1,
        ST_HANDLER  = 2'd2
    } seq_state_t;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/pc_mux.sv
// rtl/pc_mux.sv - next-PC priority select: interrupt > eret > branch > sequential
module pc_mux
    import pc_seq_ctrl_pkg::*;
(
    input  logic        sel_int,
    input  logic        sel_eret,
    input  logic        sel_br,
    input  logic [31:0] pc,
    input  logic [31:0] br_target,
    input  logic [31:0] epc,
    output logic [31:0] npc
);

    always_comb begin
        npc = pc + 32'd4;
        if (sel_int) begin
            npc = HANDLER_PC;
        end else if (sel_eret) begin
            npc = epc;
        end else if (sel_br) begin
            npc = br_target;
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - next-PC sequencer with stall gating and interrupt-entry/ERET state machine
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        hazard_stall,
    input  logic        md_stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        int_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        pc_we,
    output logic        flush_f,
    output logic        int_ack,
    output logic        in_handler
);

    seq_state_t  r_state;
    seq_state_t  w_next_state;
    logic        w_stall_any;
    logic        w_sel_int;
    logic        w_sel_eret;
    logic        w_sel_br;
    logic        w_pc_we;
    logic        w_flush;
    logic        w_ack;
    logic [31:0] w_mux_npc;

    assign w_stall_any = hazard_stall | md_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_sel_int    = 1'b0;
        w_sel_eret   = 1'b0;
        w_sel_br     = 1'b0;
        w_pc_we      = 1'b0;
        w_flush      = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            ST_INT_PEND: begin
                // Branch/eret are dropped here; a withdrawn request just resumes sequential fetch
                if (!int_req) begin
                    w_next_state = ST_RUN;
                    w_pc_we      = !w_stall_any;
                end else if (!w_stall_any) begin
                    w_sel_int    = 1'b1;
                    w_pc_we      = 1'b1;
                    w_flush      = 1'b1;
                    w_ack        = 1'b1;
                    w_next_state = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (!w_stall_any) begin
                    w_pc_we = 1'b1;
                    if (eret) begin
                        w_sel_eret   = 1'b1;
                        w_flush      = 1'b1;
                        w_next_state = ST_RUN;
                    end else begin
                        w_sel_br = br_valid;
                    end
                end
            end
            default: begin
                // RUN, and any unused encoding recovers through RUN
                w_next_state = ST_RUN;
                if (int_req) begin
                    if (!w_stall_any) begin
                        w_sel_int    = 1'b1;
                        w_pc_we      = 1'b1;
                        w_flush      = 1'b1;
                        w_ack        = 1'b1;
                        w_next_state = ST_HANDLER;
                    end else begin
                        w_next_state = ST_INT_PEND;
                    end
                end else if (!w_stall_any) begin
                    w_pc_we = 1'b1;
                    if (eret) begin
                        w_sel_eret = 1'b1;
                        w_flush    = 1'b1;
                    end else begin
                        w_sel_br = br_valid;
                    end
                end
            end
        endcase
    end

    pc_mux u_pc_mux (
        .sel_int   (w_sel_int),
        .sel_eret  (w_sel_eret),
        .sel_br    (w_sel_br),
        .pc        (pc),
        .br_target (br_target),
        .epc       (epc),
        .npc       (w_mux_npc)
    );

    assign npc        = reset ? w_mux_npc : RESET_PC;
    assign pc_we      = reset & w_pc_we;
    assign flush_f    = reset & w_flush;
    assign int_ack    = reset & w_ack;
    assign in_handler = reset & (r_state == ST_HANDLER);

endmodule
